// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit with a small prefetch queue. Issues word-aligned
// fetch requests to instruction memory, writes the in-order responses into a
// DEPTH-entry queue together with their fetch address, and presents the queue
// head to the decode stage. A redirect (PC_src) restarts fetching at
// branch_target, flushes the queue and discards the responses still owed for
// requests issued before the redirect.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr     fetch request channel
//   imem_rsp_valid, imem_rsp_data       in-order response channel
//   instr_valid/ready, instr, instr_pc  queue head towards decode
//   cond, op, funct, rd                 field slices of instr
//   PC_src, branch_target               redirect from the control unit
//
// Optional build macro INSTR_FETCH_PERF_EN adds two saturating 16-bit
// counters: perf_stall_cnt (cycles with an empty head) and perf_flush_cnt
// (redirect cycles).
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rd,
    input  logic              PC_src,
    input  logic [ADDR_W-1:0] branch_target
`ifdef INSTR_FETCH_PERF_EN
    ,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    // Address of the next response that will be kept: responses arrive in
    // order, so no per-request address FIFO is needed.
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;
    logic [CNT_W-1:0]  occ_q, occ_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    // Holds requests off until the first edge after reset release.
    logic              started_q;

    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic accept;
    logic push;
    logic pop;

    // Credit check: every outstanding request owns a queue slot, so a
    // response can always be written without overflow.
    assign imem_req_valid = started_q &&
                            (({1'b0, outstanding_q} + {1'b0, occ_q}) < DEPTH_V);
    assign imem_addr      = fetch_pc_q;
    assign accept         = imem_req_valid & imem_req_ready;
    // A response in a redirect cycle belongs to the old stream: drop it.
    assign push           = imem_rsp_valid & (discard_q == '0) & ~PC_src;
    assign instr_valid    = (occ_q != '0);
    assign pop            = instr_valid & instr_ready;

    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        occ_d         = occ_q + CNT_W'(push) - CNT_W'(pop);
        head_d        = head_q + PTR_W'(pop);
        tail_d        = tail_q + PTR_W'(push);

        if (accept) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
        if (push) begin
            rsp_pc_d = rsp_pc_q + ADDR_W'(4);
        end
        if (imem_rsp_valid && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        if (PC_src) begin
            // Every request still outstanding after this cycle (remaining
            // discards plus those issued since) is from the abandoned stream.
            discard_d  = outstanding_d;
            fetch_pc_d = branch_target & ~ADDR_W'(3);
            rsp_pc_d   = branch_target & ~ADDR_W'(3);
            occ_d      = '0;
            head_d     = '0;
            tail_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            occ_q         <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            occ_q         <= occ_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            started_q     <= 1'b1;
        end
    end

    // Queue storage needs no reset: an entry is only visible once occupancy
    // covers it. The queue is tiny, so the head is read combinationally to
    // keep response-to-instr_valid latency at one cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (tail_q == PTR_W'(gi))) begin
                    data_mem[gi] <= imem_rsp_data;
                    pc_mem[gi]   <= rsp_pc_q;
                end
            end
        end
    endgenerate

    assign instr    = instr_valid ? data_mem[head_q] : 32'h0;
    assign instr_pc = instr_valid ? pc_mem[head_q]   : '0;
    assign cond     = instr[31:28];
    assign op       = instr[27:26];
    assign funct    = instr[25:20];
    assign rd       = instr[15:12];

`ifdef INSTR_FETCH_PERF_EN
    logic [15:0] perf_stall_q;
    logic [15:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (!instr_valid && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
            if (PC_src && (perf_flush_q != 16'hFFFF)) begin
                perf_flush_q <= perf_flush_q + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    // Performance counters are not present in this build.
`endif

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int NCYC  = 800;
    localparam int RST_CYC = 400;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req_valid;
    logic          imem_req_ready = 1'b0;
    logic [AW-1:0] imem_addr;
    logic          imem_rsp_valid = 1'b0;
    logic [31:0]   imem_rsp_data = '0;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;
    logic [3:0]    cond;
    logic [1:0]    op;
    logic [5:0]    funct;
    logic [3:0]    rd;
    logic          PC_src = 1'b0;
    logic [AW-1:0] branch_target = '0;
`ifdef INSTR_FETCH_PERF_EN
    logic [15:0]   perf_stall_cnt;
    logic [15:0]   perf_flush_cnt;
`endif

    instr_fetch #(
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .RESET_PC ('0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .cond           (cond),
        .op             (op),
        .funct          (funct),
        .rd             (rd),
        .PC_src         (PC_src),
        .branch_target  (branch_target)
`ifdef INSTR_FETCH_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: memory requests tagged with the fetch stream (epoch)
    // they belong to; a response survives only if its stream is still live.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          cyc;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ins_t;

    req_t        pend[$];
    ins_t        expq[$];
    int          tests = 0;
    int          fails = 0;
    int          pops = 0;
    int          epoch = 0;
    logic [31:0] mpc = '0;
    bit          started = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hE081_2003;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ a;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: checks every instruction the DUT hands to decode.
    ins_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready) begin
                if (expq.size() == 0) begin
                    chk("pop_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = expq.pop_front();
                    pops++;
                    $display("[TB] pop pc=%08h instr=%08h", instr_pc, instr);
                    chk("instr_pc", instr_pc, mon_e.pc);
                    chk("instr",    instr,    mon_e.data);
                    chk("cond",     cond,     mon_e.data[31:28]);
                    chk("op",       op,       mon_e.data[27:26]);
                    chk("funct",    funct,    mon_e.data[25:20]);
                    chk("rd",       rd,       mon_e.data[15:12]);
                end
            end
            if (!instr_valid) chk("instr_zero", instr, 64'd0);
        end
    end

    task automatic check_reset_outputs();
        chk("rst_req_valid",   imem_req_valid, 64'd0);
        chk("rst_instr_valid", instr_valid,    64'd0);
        chk("rst_instr",       instr,          64'd0);
        chk("rst_instr_pc",    instr_pc,       64'd0);
        chk("rst_imem_addr",   imem_addr,      64'd0);
`ifdef INSTR_FETCH_PERF_EN
        chk("rst_perf_stall",  perf_stall_cnt, 64'd0);
        chk("rst_perf_flush",  perf_flush_cnt, 64'd0);
`endif
    endtask

    req_t r;
    bit   rr, ir, rs, pcs;
    logic [31:0] tgt;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        #2 rst_n = 1'b1;
        started = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // State of this cycle against the credit / fetch-PC rules.
            chk("req_valid", imem_req_valid,
                64'(started && ((pend.size() + expq.size()) < DEPTH)));
            chk("imem_addr", imem_addr, mpc);
            chk("instr_valid", instr_valid, 64'(expq.size() != 0));

            rr = 1'b1; ir = 1'b1; rs = 1'b1; pcs = 1'b0; tgt = '0;
            if (c >= 30 && c < 40) ir = 1'b0;
            if (c == 45) begin pcs = 1'b1; tgt = 32'h100; end
            if (c >= 50 && c < 55) rr = 1'b0;
            if (c >= 60 && c < 64) rs = 1'b0;
            if (c == 63) begin pcs = 1'b1; tgt = 32'h200; end
            if (c >= 70) begin
                rr  = ($urandom_range(0, 3) != 0);
                ir  = ($urandom_range(0, 9) < 7);
                rs  = ($urandom_range(0, 9) < 6);
                pcs = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF8;
                else tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            end

            imem_req_ready = rr;
            instr_ready    = ir;
            PC_src         = pcs;
            branch_target  = tgt;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            if (rs && pend.size() > 0 && pend[0].cyc < c) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend[0].addr);
            end

            if (c == RST_CYC) begin
                imem_rsp_valid = 1'b0;
                PC_src = 1'b0;
                #2 rst_n = 1'b0;
                #1 check_reset_outputs();
                $display("[TB] async reset at cycle %0d", c);
                pend.delete();
                expq.delete();
                epoch++;
                mpc = '0;
                started = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
                started = 1'b1;
                continue;
            end

            @(negedge clk);
            #1;
            if (imem_rsp_valid) begin
                r = pend.pop_front();
                if (r.epoch == epoch && !PC_src)
                    expq.push_back('{pc: r.addr, data: mem_word(r.addr)});
            end
            if (imem_req_valid && imem_req_ready)
                pend.push_back('{addr: mpc, epoch: epoch, cyc: c});
            if (PC_src) begin
                expq.delete();
                epoch++;
                mpc = tgt;
            end else if (imem_req_valid && imem_req_ready) begin
                mpc = mpc + 32'd4;
            end
        end

        chk("progress", 64'(pops >= 50), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
